// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue
//   Instruction fetch front end for the single-cycle datapath. Issues sequential
//   fetch requests to a request/response instruction memory, buffers returned
//   words together with their PC in a small FIFO, and hands them to decode with
//   a valid/ready handshake. A redirect flushes the FIFO, restarts fetch at the
//   new target and throws away responses that were already in flight.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
//   high. imem_req_valid depends only on registered state, never on ready or
//   redirect. imem_rsp_valid has no ready; responses come back in request order.
//   inst_valid/inst/inst_pc are registered-state driven; a pop happens on
//   inst_valid & inst_ready.
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous active-low reset
//   redirect        flush and restart fetch at redirect_pc
//   redirect_pc     new fetch address, bits [1:0] ignored
//   imem_req_valid  fetch request valid
//   imem_req_addr   fetch address (current fetch PC)
//   imem_req_ready  memory accepts the request
//   imem_rsp_valid  response word valid
//   imem_rsp_data   returned instruction word
//   inst_valid      head-of-queue entry valid
//   inst            head instruction (0 when empty)
//   inst_pc         PC of head instruction (0 when empty)
//   inst_ready      consumer takes the head entry
//   dbg_state       FSM state (0 BOOT, 1 RUN, 2 FLUSH)
//   dbg_fifo_count  entries held in the FIFO
//   dbg_outstanding requests issued but not yet answered

module inst_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    localparam int         CW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    output logic          imem_req_valid,
    output logic [31:0]   imem_req_addr,
    input  logic          imem_req_ready,
    input  logic          imem_rsp_valid,
    input  logic [31:0]   imem_rsp_data,
    output logic          inst_valid,
    output logic [31:0]   inst,
    output logic [31:0]   inst_pc,
    input  logic          inst_ready,
    output logic [1:0]    dbg_state,
    output logic [CW-1:0] dbg_fifo_count,
    output logic [CW-1:0] dbg_outstanding
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] fifo_count, outstanding, drop_cnt, outstanding_next;
    logic [31:0]   fetch_pc, rsp_pc, target_pc;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [31:0]   mem_data [DEPTH];
    logic [31:0]   mem_pc   [DEPTH];
    logic [CW:0]   occupancy;
    logic          req_fire, rsp_accept, push, pop;
    logic          redirect_pc_unused;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign redirect_pc_unused = ^redirect_pc[1:0];
    assign target_pc          = {redirect_pc[31:2], 2'b00};

    // Requests are capped so that every in-flight word already has a FIFO slot.
    assign occupancy      = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imem_req_valid = (state == RUN) && (occupancy < (CW + 1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_accept = imem_rsp_valid && (outstanding != '0);
    // Only RUN with no stale words pending keeps a response; redirect drops it.
    assign push = rsp_accept && (state == RUN) && (drop_cnt == '0) && !redirect;
    assign pop  = inst_valid && inst_ready && !redirect;

    assign outstanding_next = outstanding + CW'(req_fire) - CW'(rsp_accept);

    assign inst_valid = (fifo_count != '0);
    assign inst       = inst_valid ? mem_data[rd_ptr] : 32'h0;
    assign inst_pc    = inst_valid ? mem_pc[rd_ptr]   : 32'h0;

    assign dbg_state       = state;
    assign dbg_fifo_count  = fifo_count;
    assign dbg_outstanding = outstanding;

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     state_next = RUN;
            FLUSH: begin
                // Leave on the same cycle the last stale word arrives.
                if (drop_cnt == '0 || (rsp_accept && drop_cnt == CW'(1)))
                    state_next = RUN;
            end
            default: state_next = BOOT;
        endcase
        if (redirect)
            state_next = (outstanding_next != '0) ? FLUSH : RUN;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            fifo_count  <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_next;
            if (redirect) begin
                fetch_pc   <= target_pc;
                rsp_pc     <= target_pc;
                // Everything still in flight after this cycle is stale.
                drop_cnt   <= outstanding_next;
                fifo_count <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + 32'd4;
                if (push) begin
                    rsp_pc <= rsp_pc + 32'd4;
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (pop)
                    rd_ptr <= ptr_inc(rd_ptr);
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
                if (state == FLUSH && rsp_accept && drop_cnt != '0)
                    drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read while fifo_count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= imem_rsp_data;
            mem_pc[wr_ptr]   <= rsp_pc;
        end
    end

endmodule
